// File: rtl/tile_pkg.sv
// Shared types and constants for the tile spawner and the other game blocks.
// Contents: FSM state enum, LFSR geometry and taps, tile value codes, default seed.
package tile_pkg;

    // Spawner sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
    // With a left shift the exponents map to state bits 15, 13, 12 and 10.
    localparam int          LFSR_W       = 16;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Tile encodings (log2 of the face value; 0 marks an empty cell).
    localparam int VAL_EMPTY = 0;
    localparam int VAL_TWO   = 1;
    localparam int VAL_FOUR  = 2;

    // One LFSR step: shift left, XOR of the tapped bits enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR. Steps on every clock edge, reloads SEED
// on reset. Shared randomness source for the game blocks.
module lfsr16
    import tile_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;

    // Advance the sequence every cycle; reset restores the seed.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/tile_spawner.sv
// Tile spawner for the 2048 board datapath. On an accepted start it snapshots
// the board, starts at an LFSR-chosen cell and walks the cells one per cycle
// (wrapping) until it finds an empty one, writes a new tile there and pulses
// done. A board with no empty cell completes with full=1 and is passed through.
// Build option: define SPAWN_FOUR_EN to spawn a "4" tile when lfsr[7:4]==0 at
// the write cycle; otherwise every new tile is a "2".
module tile_spawner
    import tile_pkg::*;
#(
    parameter int          CELLS = 16,
    parameter int          VAL_W = 4,
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          IDX_W = $clog2(CELLS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CELLS-1:0][VAL_W-1:0] cell_matrix_in,
    output logic [CELLS-1:0][VAL_W-1:0] cell_matrix_out,
    output logic [IDX_W-1:0]            spawn_idx,
    output logic                        spawned,
    output logic                        full,
    output logic                        busy,
    output logic                        done
);

    state_t                      r_state;
    logic [CELLS-1:0][VAL_W-1:0] r_board;
    logic [IDX_W-1:0]            r_idx;
    logic [IDX_W-1:0]            r_cnt;

    logic [CELLS-1:0][VAL_W-1:0] r_matrix_out;
    logic [IDX_W-1:0]            r_spawn_idx;
    logic                        r_spawned;
    logic                        r_full;
    logic                        r_busy;
    logic                        r_done;

    logic [LFSR_W-1:0]           w_lfsr;
    logic                        w_accept;
    logic                        w_cell_empty;
    logic                        w_last_cell;
    logic [VAL_W-1:0]            w_spawn_val;
    logic [CELLS-1:0][VAL_W-1:0] w_board_spawned;
    logic                        w_unused_lfsr;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_state (w_lfsr)
    );

    // Only the low index bits (and the 4-tile nibble, when enabled) are consumed.
    assign w_unused_lfsr = ^w_lfsr;

    assign w_accept     = (r_state == IDLE) && start;
    assign w_cell_empty = (r_board[r_idx] == VAL_W'(VAL_EMPTY));
    assign w_last_cell  = (r_cnt == IDX_W'(CELLS - 1));

`ifdef SPAWN_FOUR_EN
    // A "4" tile when the LFSR nibble [7:4] is zero in the write cycle (~1/16).
    assign w_spawn_val = (w_lfsr[7:4] == 4'h0) ? VAL_W'(VAL_FOUR) : VAL_W'(VAL_TWO);
`else
    // Every new tile is a "2".
    assign w_spawn_val = VAL_W'(VAL_TWO);
`endif

    // Working board with the new tile dropped into the cell under the cursor.
    // NOTE: the full default assignment comes first so every bit is driven on
    // every path and no latch is inferred for the untouched cells.
    always_comb begin
        w_board_spawned        = r_board;
        w_board_spawned[r_idx] = w_spawn_val;
    end

    // Snapshot of the incoming board, taken only on an accepted start.
    // NOTE: this working copy is deliberately left out of reset: it is always
    // reloaded before it is read, and nothing reaches the outputs without an
    // accepted start, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_board <= cell_matrix_in;
        end
    end

    // Spawn sequencer: IDLE -> SCAN (one cell per cycle) -> DONE -> IDLE,
    // with all status outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_matrix_out <= '0;
            r_spawn_idx  <= '0;
            r_spawned    <= 1'b0;
            r_full       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_idx       <= w_lfsr[IDX_W-1:0];
                        r_cnt       <= '0;
                        r_spawn_idx <= '0;
                        r_spawned   <= 1'b0;
                        r_full      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= SCAN;
                    end
                end

                SCAN: begin
                    if (w_cell_empty) begin
                        r_matrix_out <= w_board_spawned;
                        r_spawn_idx  <= r_idx;
                        r_spawned    <= 1'b1;
                        r_done       <= 1'b1;
                        r_state      <= DONE;
                    end else if (w_last_cell) begin
                        // Every cell examined and occupied: pass the board through.
                        r_matrix_out <= r_board;
                        r_full       <= 1'b1;
                        r_done       <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        // Power-of-two CELLS makes the increment wrap naturally.
                        r_idx <= r_idx + IDX_W'(1);
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cell_matrix_out = r_matrix_out;
    assign spawn_idx       = r_spawn_idx;
    assign spawned         = r_spawned;
    assign full            = r_full;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_tile_spawner.sv
// Self-checking bench for tile_spawner: a behavioural model (LFSR sequence plus
// a modular search for the first empty cell) predicts every transaction, and
// one compare process checks all outputs on every cycle.
module tb_tile_spawner;

    localparam int          CELLS = 16;
    localparam int          VAL_W = 4;
    localparam int          IDX_W = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          BW    = CELLS * VAL_W;

    typedef logic [CELLS-1:0][VAL_W-1:0] board_t;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    board_t           din   = '0;
    board_t           dout;
    logic [IDX_W-1:0] spawn_idx;
    logic             spawned;
    logic             full;
    logic             busy;
    logic             done;

    tile_spawner #(
        .CELLS (CELLS),
        .VAL_W (VAL_W),
        .SEED  (SEED)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cell_matrix_in  (din),
        .cell_matrix_out (dout),
        .spawn_idx       (spawn_idx),
        .spawned         (spawned),
        .full            (full),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // x^16+x^14+x^13+x^11+1, shifted left, feedback into bit 0.
    function automatic logic [15:0] model_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Cycle counter and model LFSR, both advancing on each rising edge.
    int          cyc = 0;
    logic [15:0] m_lfsr = SEED;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= model_step(m_lfsr);
    end

    // Expected transaction (written by the stimulus side).
    int               n_issued = 0;
    int               e0 = 0;
    int               k  = 0;
    board_t           x_board;
    logic [IDX_W-1:0] x_idx;
    logic             x_spawned;
    logic             x_full;

    // Held results and completion bookkeeping (written by the compare side).
    int               n_done = 0;
    int               last_done = 0;
    board_t           h_board = '0;
    logic [IDX_W-1:0] h_idx = '0;
    logic             h_spawned = 1'b0;
    logic             h_full = 1'b0;

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        bit pend, in_scan, at_done;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_spawned", spawned, 0);
                check("rst_full", full, 0);
                check("rst_idx", spawn_idx, 0);
                check("rst_board", dout, 0);
                n_done    = n_issued;
                h_board   = '0;
                h_idx     = '0;
                h_spawned = 1'b0;
                h_full    = 1'b0;
            end else begin
                pend    = (n_issued != n_done);
                in_scan = pend && (cyc >= e0) && (cyc < e0 + k);
                at_done = pend && (cyc == e0 + k);
                check("busy", busy, in_scan || at_done);
                check("done", done, at_done);
                if (in_scan) begin
                    check("scan_spawned", spawned, 0);
                    check("scan_full", full, 0);
                    check("scan_idx", spawn_idx, 0);
                    check("scan_board", dout, h_board);
                end else if (at_done) begin
                    check("done_spawned", spawned, x_spawned);
                    check("done_full", full, x_full);
                    check("done_idx", spawn_idx, x_idx);
                    check("done_board", dout, x_board);
                    h_board   = x_board;
                    h_idx     = x_idx;
                    h_spawned = x_spawned;
                    h_full    = x_full;
                    last_done = cyc;
                    n_done++;
                end else begin
                    check("hold_spawned", spawned, h_spawned);
                    check("hold_full", full, h_full);
                    check("hold_idx", spawn_idx, h_idx);
                    check("hold_board", dout, h_board);
                end
            end
        end
    end

    // Present a board and raise start; want>=0 waits for that model start index.
    task automatic issue(input board_t b, input int want);
        logic [15:0] l;
        int          s, tries, xi;
        bit          found;
        logic [VAL_W-1:0] val;
        din   = b;
        tries = 0;
        do begin
            @(negedge clk);
            #2;
            tries++;
        end while (want >= 0 && int'(m_lfsr[IDX_W-1:0]) != want && tries < 300);
        l     = m_lfsr;
        s     = int'(l[IDX_W-1:0]);
        found = 1'b0;
        xi    = 0;
        k     = CELLS;
        for (int j = 0; j < CELLS; j++) begin
            if (!found && b[(s + j) % CELLS] == '0) begin
                found = 1'b1;
                xi    = (s + j) % CELLS;
                k     = j + 1;
            end
        end
        for (int j = 0; j < k; j++) l = model_step(l);
`ifdef SPAWN_FOUR_EN
        val = (l[7:4] == 4'h0) ? VAL_W'(2) : VAL_W'(1);
`else
        val = VAL_W'(1);
`endif
        x_board = b;
        if (found) x_board[xi] = val;
        x_idx     = found ? IDX_W'(xi) : '0;
        x_spawned = found;
        x_full    = !found;
        e0        = cyc + 1;
        start     = 1'b1;
        n_issued++;
        @(negedge clk);
        #2;
        start = 1'b0;
        din   = {$urandom, $urandom};
    endtask

    // Wait (bounded) for the compare process to see done; returns latency.
    task automatic wait_done(output int lat);
        int w = 0;
        while (n_issued != n_done && w < CELLS + 4) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (n_issued != n_done) begin
            check("done_timeout", 0, 1);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        lat = last_done - (e0 - 1);
    endtask

    task automatic spawn(input board_t b, input int want, output int lat);
        issue(b, want);
        wait_done(lat);
    endtask

    initial begin
        board_t b;
        int     lat, twos, others, n_runs, d;

        // Pin the model LFSR itself.
        check("model_lfsr_step", model_step(16'hACE1), 16'h59C3);

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Empty board at the first edge after reset: index = SEED[3:0] = 1.
        b = '0;
        spawn(b, -1, lat);
        check("empty_latency", lat, 2);
        check("empty_idx", spawn_idx, 1);
        check("empty_board", dout, 64'h0000_0000_0000_0010);
        check("empty_spawned", spawned, 1);
        check("empty_full", full, 0);

        // Full board: 17-cycle latency, board passed through.
        b = {CELLS{4'h1}};
        spawn(b, -1, lat);
        check("full_latency", lat, 17);
        check("full_flag", full, 1);
        check("full_spawned", spawned, 0);
        check("full_board", dout, {CELLS{4'h1}});

        // Single hole at cell 9.
        b = {CELLS{4'h3}};
        b[9] = '0;
        spawn(b, -1, lat);
        check("c9_idx", spawn_idx, 9);
        check("c9_cell", dout[9], 1);
        check("c9_lat_range", (lat >= 2 && lat <= 17), 1);

        // Wrap-around: start at 15, cells 15 and 0 occupied, 1 empty.
        b = '0;
        b[15] = 4'h3;
        b[0]  = 4'h3;
        spawn(b, 15, lat);
        check("wrap_idx", spawn_idx, 1);
        check("wrap_latency", lat, 4);

        // Extra start during SCAN is ignored; reset mid-SCAN aborts.
        b = {CELLS{4'h2}};
        issue(b, -1);
        repeat (3) @(negedge clk);
        #2 start = 1'b1;
        @(negedge clk);
        #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("abort_busy", busy, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        b = '0;
        spawn(b, -1, lat);
        check("post_rst_idx", spawn_idx, 1);
        check("post_rst_latency", lat, 2);

        // Random boards of random density with random idle gaps.
        for (int t = 0; t < 150; t++) begin
            d = $urandom_range(0, 16);
            for (int c = 0; c < CELLS; c++) begin
                if ($urandom_range(0, 15) < d) b[c] = '0;
                else                           b[c] = VAL_W'($urandom_range(1, 15));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            spawn(b, -1, lat);
        end

        // Spawn-value statistics on cleared boards.
`ifdef SPAWN_FOUR_EN
        n_runs = 2000;
`else
        n_runs = 200;
`endif
        twos   = 0;
        others = 0;
        for (int t = 0; t < n_runs; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            spawn('0, -1, lat);
            if (dout[spawn_idx] == 4'h2)      twos++;
            else if (dout[spawn_idx] != 4'h1) others++;
        end
        check("value_others", others, 0);
`ifdef SPAWN_FOUR_EN
        check("four_ratio", (twos >= 80 && twos <= 170), 1);
`else
        check("four_absent", twos, 0);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
